// File: rtl/weight_update_pkg.sv
// weight_update_pkg
// Shared constants for the weight_update block: default datapath geometry,
// FSM state encoding, the fixed parameter index order and the reset image
// of the parameter bank.
package weight_update_pkg;

  localparam int P_DWIDTH = 32;  // width of data, weights, biases, lr
  localparam int P_FRAC   = 24;  // fractional bits of the fixed-point format
  localparam int P_NPARAM = 17;  // number of weights + biases

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Order in which gradients arrive during a pass.
  localparam int IDX_WA11   = 0;
  localparam int IDX_WA12   = 1;
  localparam int IDX_WA13   = 2;
  localparam int IDX_WB11   = 3;
  localparam int IDX_WB12   = 4;
  localparam int IDX_WB13   = 5;
  localparam int IDX_WA21   = 6;
  localparam int IDX_WA22   = 7;
  localparam int IDX_WB21   = 8;
  localparam int IDX_WB22   = 9;
  localparam int IDX_WC21   = 10;
  localparam int IDX_WC22   = 11;
  localparam int IDX_BIAS11 = 12;
  localparam int IDX_BIAS12 = 13;
  localparam int IDX_BIAS13 = 14;
  localparam int IDX_BIAS21 = 15;
  localparam int IDX_BIAS22 = 16;

  // Reset image of the parameter bank, entry i is parameter idx i.
  localparam logic [P_NPARAM-1:0][P_DWIDTH-1:0] PARAM_INIT = '0;

endpackage

// File: rtl/weight_update_sat.sv
// sat_update
// Combinational datapath for one parameter update:
//   delta = i_product >>> FRAC   (floor), saturated to DWIDTH
//   o_new = i_param - delta,      saturated to DWIDTH
// Ports:
//   i_product : 2*DWIDTH signed, registered lr*grad product
//   i_param   : DWIDTH signed, current parameter value
//   o_new     : DWIDTH signed, updated parameter value
module sat_update #(
  parameter int DWIDTH = 32,
  parameter int FRAC   = 24
) (
  input  logic signed [2*DWIDTH-1:0] i_product,
  input  logic signed [DWIDTH-1:0]   i_param,
  output logic signed [DWIDTH-1:0]   o_new
);

  localparam logic signed [DWIDTH-1:0] MAXV = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic signed [DWIDTH-1:0] MINV = {1'b1, {(DWIDTH-1){1'b0}}};

  logic signed [2*DWIDTH-1:0] w_shifted;
  logic        [DWIDTH:0]     w_hi;
  logic signed [DWIDTH-1:0]   w_delta;
  logic signed [DWIDTH:0]     w_diff;

  assign w_shifted = i_product >>> FRAC;
  // Bits above the DWIDTH result, plus its sign bit: all equal means it fits.
  assign w_hi = w_shifted[2*DWIDTH-1:DWIDTH-1];

  always_comb begin
    w_delta = w_shifted[DWIDTH-1:0];
    if (!((&w_hi) || (~|w_hi))) begin
      w_delta = w_shifted[2*DWIDTH-1] ? MINV : MAXV;
    end
  end

  // One guard bit is enough for the difference of two DWIDTH values.
  assign w_diff = $signed({i_param[DWIDTH-1], i_param}) -
                  $signed({w_delta[DWIDTH-1], w_delta});

  always_comb begin
    o_new = w_diff[DWIDTH-1:0];
    if (w_diff[DWIDTH] != w_diff[DWIDTH-1]) begin
      o_new = w_diff[DWIDTH] ? MINV : MAXV;
    end
  end

endmodule

// File: rtl/weight_update.sv
// weight_update
// Gradient-descent update of a 17-entry weight/bias bank. A pass starts on
// start in IDLE (lr captured), then for each parameter in fixed order accepts
// one gradient (RECV, valid/ready), and applies param -= sat(lr*grad >> frac)
// with saturation (CALC). After the last parameter, done pulses for one cycle.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   start, lr              : begin a pass / learning rate captured with it
//   grad_data, grad_valid  : gradient stream input
//   grad_ready             : high in RECV only
//   busy, done             : pass in progress / end-of-pass pulse
//   wa11 .. bias22         : live parameter register bank
module weight_update
  import weight_update_pkg::*;
#(
  parameter int DWIDTH = P_DWIDTH,
  parameter int frac   = P_FRAC,
  parameter int NPARAM = P_NPARAM
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DWIDTH-1:0] lr,
  input  logic signed [DWIDTH-1:0] grad_data,
  input  logic                     grad_valid,
  output logic                     grad_ready,
  output logic                     busy,
  output logic                     done,
  output logic signed [DWIDTH-1:0] wa11,
  output logic signed [DWIDTH-1:0] wa12,
  output logic signed [DWIDTH-1:0] wa13,
  output logic signed [DWIDTH-1:0] wb11,
  output logic signed [DWIDTH-1:0] wb12,
  output logic signed [DWIDTH-1:0] wb13,
  output logic signed [DWIDTH-1:0] wa21,
  output logic signed [DWIDTH-1:0] wa22,
  output logic signed [DWIDTH-1:0] wb21,
  output logic signed [DWIDTH-1:0] wb22,
  output logic signed [DWIDTH-1:0] wc21,
  output logic signed [DWIDTH-1:0] wc22,
  output logic signed [DWIDTH-1:0] bias11,
  output logic signed [DWIDTH-1:0] bias12,
  output logic signed [DWIDTH-1:0] bias13,
  output logic signed [DWIDTH-1:0] bias21,
  output logic signed [DWIDTH-1:0] bias22
);

  localparam int IW = $clog2(NPARAM);
  localparam logic [IW-1:0] LAST_IDX = IW'(NPARAM - 1);

  state_t                     r_state;
  logic [IW-1:0]              r_idx;
  logic signed [DWIDTH-1:0]   r_lr;
  logic signed [2*DWIDTH-1:0] r_product;
  logic signed [DWIDTH-1:0]   r_param [NPARAM];
  logic                       r_ready;
  logic                       r_busy;
  logic                       r_done;

  logic signed [2*DWIDTH-1:0] w_lr_ext;
  logic signed [2*DWIDTH-1:0] w_grad_ext;
  logic signed [DWIDTH-1:0]   w_new;

  // Sign-extend both operands so the product keeps all 2*DWIDTH bits.
  assign w_lr_ext   = (2*DWIDTH)'(r_lr);
  assign w_grad_ext = (2*DWIDTH)'(grad_data);

  sat_update #(
    .DWIDTH (DWIDTH),
    .FRAC   (frac)
  ) u_sat (
    .i_product (r_product),
    .i_param   (r_param[r_idx]),
    .o_new     (w_new)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_lr      <= '0;
      r_product <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      for (int i = 0; i < NPARAM; i++) begin
        r_param[i] <= PARAM_INIT[i][DWIDTH-1:0];
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_lr    <= lr;
            r_idx   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_RECV;
          end
        end
        S_RECV: begin
          if (grad_valid) begin
            r_product <= w_lr_ext * w_grad_ext;
            r_ready   <= 1'b0;
            r_state   <= S_CALC;
          end
        end
        S_CALC: begin
          r_param[r_idx] <= w_new;
          if (r_idx == LAST_IDX) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + IW'(1);
            r_ready <= 1'b1;
            r_state <= S_RECV;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign grad_ready = r_ready;
  assign busy       = r_busy;
  assign done       = r_done;

  assign wa11   = r_param[IDX_WA11];
  assign wa12   = r_param[IDX_WA12];
  assign wa13   = r_param[IDX_WA13];
  assign wb11   = r_param[IDX_WB11];
  assign wb12   = r_param[IDX_WB12];
  assign wb13   = r_param[IDX_WB13];
  assign wa21   = r_param[IDX_WA21];
  assign wa22   = r_param[IDX_WA22];
  assign wb21   = r_param[IDX_WB21];
  assign wb22   = r_param[IDX_WB22];
  assign wc21   = r_param[IDX_WC21];
  assign wc22   = r_param[IDX_WC22];
  assign bias11 = r_param[IDX_BIAS11];
  assign bias12 = r_param[IDX_BIAS12];
  assign bias13 = r_param[IDX_BIAS13];
  assign bias21 = r_param[IDX_BIAS21];
  assign bias22 = r_param[IDX_BIAS22];

endmodule

// File: tb/tb_weight_update.sv
// tb_weight_update
// Scoreboard bench: each completed stimulus pass pushes the 17 expected
// parameter values (from a plain-arithmetic model) into a queue; a monitor
// pops and compares them whenever the DUT pulses done.
module tb_weight_update;

  localparam int NP = 17;
  localparam longint MAXL = 64'sh0000_0000_7FFF_FFFF;
  localparam longint MINL = -64'sh0000_0000_8000_0000;

  logic clk = 1'b0;
  logic rst, start, grad_valid;
  logic signed [31:0] lr, grad_data;
  logic grad_ready, busy, done;
  logic signed [31:0] wa11, wa12, wa13, wb11, wb12, wb13, wa21, wa22;
  logic signed [31:0] wb21, wb22, wc21, wc22;
  logic signed [31:0] bias11, bias12, bias13, bias21, bias22;
  logic [31:0] dut_p [NP];

  int n_vec = 0;
  int n_err = 0;
  int done_seen = 0;
  longint model_p [NP];
  logic [31:0] exp_q [$];
  logic [31:0] g [NP];

  always #5 clk = ~clk;

  weight_update dut (
    .clk(clk), .rst(rst), .start(start), .lr(lr),
    .grad_data(grad_data), .grad_valid(grad_valid),
    .grad_ready(grad_ready), .busy(busy), .done(done),
    .wa11(wa11), .wa12(wa12), .wa13(wa13),
    .wb11(wb11), .wb12(wb12), .wb13(wb13),
    .wa21(wa21), .wa22(wa22), .wb21(wb21), .wb22(wb22),
    .wc21(wc21), .wc22(wc22),
    .bias11(bias11), .bias12(bias12), .bias13(bias13),
    .bias21(bias21), .bias22(bias22)
  );

  assign dut_p[0]  = wa11;   assign dut_p[1]  = wa12;   assign dut_p[2]  = wa13;
  assign dut_p[3]  = wb11;   assign dut_p[4]  = wb12;   assign dut_p[5]  = wb13;
  assign dut_p[6]  = wa21;   assign dut_p[7]  = wa22;   assign dut_p[8]  = wb21;
  assign dut_p[9]  = wb22;   assign dut_p[10] = wc21;   assign dut_p[11] = wc22;
  assign dut_p[12] = bias11; assign dut_p[13] = bias12; assign dut_p[14] = bias13;
  assign dut_p[15] = bias21; assign dut_p[16] = bias22;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic longint clamp(input longint v);
    if (v > MAXL) return MAXL;
    if (v < MINL) return MINL;
    return v;
  endfunction

  // Reference: param -= sat(floor(lr*grad / 2^24)), result saturated.
  task automatic commit_and_push(input logic [31:0] lr_v);
    longint prod, delta;
    for (int i = 0; i < NP; i++) begin
      prod = longint'($signed(lr_v)) * longint'($signed(g[i]));
      delta = clamp(prod >>> 24);
      model_p[i] = clamp(model_p[i] - delta);
      exp_q.push_back(32'(model_p[i]));
    end
  endtask

  // Monitor: every done pulse must match one queued expected bank.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_seen++;
      if (exp_q.size() < NP) begin
        n_vec++;
        n_err++;
        $display("FAIL done_unexpected: got done=1, expected no pass end (queue %0d)", exp_q.size());
      end else begin
        for (int i = 0; i < NP; i++) begin
          check($sformatf("pass_param%0d", i), dut_p[i], exp_q.pop_front());
        end
      end
    end
  end

  task automatic randomize_grads(input bit big);
    for (int i = 0; i < NP; i++) begin
      if (big && $urandom_range(0, 3) == 0) g[i] = $urandom();
      else g[i] = $urandom_range(0, 32'h0400_0000) - 32'h0200_0000;
    end
  endtask

  task automatic wait_idle(input int dn0);
    int cnt = 0;
    while (done_seen == dn0 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("done_seen", 32'(done_seen), 32'(dn0 + 1));
    cnt = 0;
    while (busy && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("busy_after_done", {31'b0, busy}, 32'd0);
  endtask

  // Back-to-back pass with cycle-exact checks of done/grad_ready/busy.
  task automatic timing_pass(input logic [31:0] lr_v);
    int dn0;
    logic [2:0] e;
    dn0 = done_seen;
    @(negedge clk);
    start = 1'b1; lr = lr_v; grad_valid = 1'b1; grad_data = g[0];
    @(posedge clk); #1;
    start = 1'b0; lr = $urandom();
    for (int n = 0; n <= 36; n++) begin
      @(negedge clk);
      e = {n == 34, (n % 2 == 0) && (n <= 32), n <= 34};
      check($sformatf("timing_edge%0d", n), {29'b0, done, grad_ready, busy}, {29'b0, e});
      if (n % 2 == 0 && n / 2 < NP) grad_data = g[n / 2];
      if (n == 33) commit_and_push(lr_v);
      if (n == 35) grad_valid = 1'b0;
    end
    check("timing_done_count", 32'(done_seen), 32'(dn0 + 1));
  endtask

  task automatic run_pass(input logic [31:0] lr_v, input bit gaps, input int stall_at,
                          input int poke_at, input int abort_at);
    int k = 0;
    int budget = 0;
    int dn0;
    bit xfer, stalled = 0;
    logic [31:0] snap [NP];
    dn0 = done_seen;
    @(negedge clk);
    start = 1'b1; lr = lr_v; grad_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; lr = $urandom();
    while (k < NP && budget < 2000) begin
      budget++;
      if (k == stall_at && !stalled) begin
        stalled = 1;
        grad_valid = 1'b0;
        @(posedge clk); #1;  // CALC edge of the previous gradient
        for (int i = 0; i < NP; i++) snap[i] = dut_p[i];
        repeat (5) begin
          @(negedge clk);
          check("stall_ready", {31'b0, grad_ready}, 32'd1);
          @(posedge clk); #1;
        end
        for (int i = 0; i < NP; i++) check($sformatf("stall_hold%0d", i), dut_p[i], snap[i]);
      end
      grad_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      grad_data = g[k];
      if (k == poke_at) begin
        start = 1'b1;
        lr = ~lr_v;
      end
      @(negedge clk);
      xfer = grad_valid && grad_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (xfer) k++;
      if (k == abort_at) begin
        grad_valid = 1'b0;
        @(posedge clk); #2;  // idx abort_at-1 is now written
        rst = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_ready", {31'b0, grad_ready}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        for (int i = 0; i < NP; i++) begin
          check($sformatf("abort_init%0d", i), dut_p[i], 32'd0);
          model_p[i] = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_done", 32'(done_seen), 32'(dn0));
        return;
      end
    end
    grad_valid = 1'b0;
    if (k < NP) begin
      n_vec++;
      n_err++;
      $display("FAIL pass_timeout: got %0d transfers, expected %0d", k, NP);
    end else begin
      commit_and_push(lr_v);
      wait_idle(dn0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; grad_valid = 1'b0; lr = '0; grad_data = '0;
    for (int i = 0; i < NP; i++) model_p[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_ready", {31'b0, grad_ready}, 32'd0);
    for (int i = 0; i < NP; i++) check($sformatf("reset_param%0d", i), dut_p[i], 32'd0);
    rst = 1'b0;

    // Single step with exact timing: wa11 = 0 - 1.0*0.5.
    for (int i = 0; i < NP; i++) g[i] = '0;
    g[0] = 32'h0080_0000;
    timing_pass(32'h0100_0000);
    check("step_wa11", wa11, 32'hFF80_0000);
    check("step_wa12", wa12, 32'h0000_0000);

    // Bring wa11 to 1.0, then force positive saturation.
    g[0] = 32'hFE80_0000;
    run_pass(32'h0100_0000, 0, -1, -1, -1);
    check("wa11_one", wa11, 32'h0100_0000);
    g[0] = 32'h8000_0000;
    run_pass(32'h0100_0000, 0, -1, -1, -1);
    check("sat_wa11", wa11, 32'h7FFF_FFFF);

    // Randomized passes: backpressure, ignored start, saturating lr.
    for (int p = 0; p < 6; p++) begin
      logic [31:0] lr_v;
      randomize_grads(p >= 4);
      lr_v = (p == 5) ? $urandom() : $urandom_range(0, 32'h0200_0000) - 32'h0100_0000;
      run_pass(lr_v, p != 1, (p == 1) ? 3 : -1, (p == 2) ? 5 : -1, -1);
    end

    // Reset after idx 8 is written, then a clean pass from PARAM_INIT.
    randomize_grads(0);
    run_pass(32'h0100_0000, 0, -1, -1, 9);
    randomize_grads(1);
    run_pass($urandom_range(0, 32'h0200_0000) - 32'h0100_0000, 1, -1, -1, -1);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/weight_update.md
WEIGHT_UPDATE -- requirements
Module: weight_update

Interface
REQ-001 SHALL have parameter DWIDTH, default 32: width of every datum, weight, bias and learning rate.
REQ-002 SHALL have parameter frac, default 24: fractional bits of the signed fixed-point format.
REQ-003 SHALL have parameter NPARAM, default 17: number of weights and biases held.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: begins one update pass when sampled high in IDLE.
REQ-007 SHALL have port lr, input, DWIDTH signed: learning rate, captured on the start edge.
REQ-008 SHALL have port grad_data, input, DWIDTH signed: gradient of the current parameter.
REQ-009 SHALL have port grad_valid, input, 1 bit: grad_data holds a valid gradient.
REQ-010 SHALL have port grad_ready, output, 1 bit: block accepts grad_data this cycle.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse marking the end of a pass.
REQ-013 SHALL have ports wa11, wa12, wa13, wb11, wb12, wb13, wa21, wa22, wb21, wb22, wc21, wc22, bias11, bias12, bias13, bias21, bias22, all outputs, DWIDTH signed each: the live parameter register bank.

Function
REQ-014 SHALL run a four-state FSM: IDLE, RECV, CALC, DONE.
REQ-015 SHALL move IDLE->RECV on start=1, capturing lr and clearing the index idx to 0; start SHALL be ignored in every other state.
REQ-016 SHALL drive grad_ready=1 only in RECV; a transfer occurs when grad_valid and grad_ready are both 1.
REQ-017 SHALL, in RECV on a transfer, register the full 2*DWIDTH signed product lr*grad_data and move to CALC; with no transfer it SHALL stay in RECV indefinitely.
REQ-018 SHALL, in CALC, compute delta = product arithmetically shifted right by frac (truncation toward minus infinity), then new = param[idx] - delta.
REQ-019 SHALL saturate delta and new to the signed DWIDTH range (0x7FFF_FFFF / 0x8000_0000), never wrap.
REQ-020 SHALL write new into param[idx] at the CALC edge; idx<NPARAM-1 -> idx+1, back to RECV; idx=NPARAM-1 -> DONE.
REQ-021 SHALL fix the index order as wa11, wa12, wa13, wb11, wb12, wb13, wa21, wa22, wb21, wb22, wc21, wc22, bias11, bias12, bias13, bias21, bias22 (idx 0..16).
REQ-022 SHALL assert done for exactly the single DONE cycle, then return to IDLE.
REQ-023 SHALL drive the output ports directly from the register bank; values change only at CALC edges, and consumers sample them only while busy=0.
REQ-024 SHALL take 2 cycles per gradient under back-to-back valid, so a pass lasts 2*NPARAM+1 cycles after the start edge.

Reset
REQ-025 SHALL, on rst=1 (asynchronous), force IDLE, idx=0, product and captured lr to 0, grad_ready/busy/done to 0, and every parameter to its PARAM_INIT value.
REQ-026 SHALL, on reset during a pass, discard the pass; partially written parameters SHALL revert to PARAM_INIT.

Structure
REQ-027 SHALL place DWIDTH, frac, NPARAM, the state encoding, the index-order constants and the PARAM_INIT table (all zero by default) in a shared package.
REQ-028 SHALL isolate the multiply/shift/subtract/saturate datapath in one sub-module, sat_update.

Verification
REQ-029 SHALL cover a single step: lr=0x0100_0000 (1.0), grad idx0=0x0080_0000 (0.5), wa11=0 -> wa11=0xFF80_0000 (-0.5); every other gradient 0 leaves its parameter unchanged.
REQ-030 SHALL cover saturation: wa11=0x0100_0000, lr=1.0, grad=0x8000_0000 -> wa11=0x7FFF_FFFF.
REQ-031 SHALL cover timing: start at edge 0 with grad_valid held high -> transfers at edges 1,3,...,33; done high only in the cycle after edge 34; busy low after edge 35.
REQ-032 SHALL cover backpressure: grad_valid low for 5 cycles in RECV -> grad_ready stays 1, idx and the parameters unchanged, and the pass completes correctly once valid returns.
REQ-033 SHALL cover start ignored: start pulsed at idx=5 -> idx continues 6 and lr stays at the originally captured value.
REQ-034 SHALL cover reset mid-pass: rst asserted after idx=8 is written -> asynchronously IDLE, all 17 outputs return to PARAM_INIT, and done never pulses.
